route_cmd_cntrl: RTL and testbench

Parametrised next-generation command controller for the follower vehicle. Accepts 8-bit commands from the command receiver and holds a queue of destination station IDs (multi-stop route), matching IDs from the station-ID reader. Drives go and in_transit to the motion controller, and a configurable piezo buzzer while obstructed. Sits between the UART/IR command receiver, the ID reader and the motion/buzzer logic.

---
 rtl/route_cmd_cntrl_pkg.sv | 16 +
 rtl/route_cmd_cntrl_if.sv | 19 +
 rtl/route_cmd_cntrl_dest_fifo.sv | 55 +++++
 rtl/route_cmd_cntrl.sv | 125 ++++++++++++
 tb/tb_route_cmd_cntrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/route_cmd_cntrl_pkg.sv
// Shared types for the route command controller: command opcodes and FSM states.
package route_pkg;

  typedef enum logic [1:0] {
    CMD_STOP   = 2'b00,
    CMD_GO     = 2'b01,
    CMD_APPEND = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_op_e;

  typedef enum logic {
    IDLE    = 1'b0,
    TRANSIT = 1'b1
  } state_e;

endpackage

// File: rtl/route_cmd_cntrl_if.sv
// Request/acknowledge bundle for the command receiver and the station-ID reader.
interface route_cmd_cntrl_if;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;

  modport master (
    output cmd, cmd_rdy, ID, ID_vld,
    input  clr_cmd_rdy, clr_ID_vld
  );

  modport slave (
    input  cmd, cmd_rdy, ID, ID_vld,
    output clr_cmd_rdy, clr_ID_vld
  );
endinterface

// File: rtl/route_cmd_cntrl_dest_fifo.sv
// Circular queue of destination IDs; flush wins over push and flush+push leaves only the new entry.
module dest_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          wr_en, rd_en;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];
  assign wr_en = push && (flush || !full);
  assign rd_en = pop && !flush && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        cnt    <= CW'(1);
      end else begin
        cnt    <= '0;
      end
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_en)      cnt <= cnt + CW'(1);
      else if (rd_en && !wr_en) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/route_cmd_cntrl.sv
// Multi-stop route controller: queues destinations, matches station IDs, drives go and the obstruction buzzer.
//   state   | meaning
//   IDLE    | no route active, IDs acknowledged and ignored
//   TRANSIT | route active, head of queue is the next station to match
module route_cmd_cntrl
  import route_pkg::*;
#(
  parameter int ID_W        = 6,
  parameter int Q_DEPTH     = 4,
  parameter int BUZZ_PERIOD = 12500,
  parameter int BUZZ_HIGH   = 6250,
  localparam int QCW        = $clog2(Q_DEPTH + 1),
  localparam int BCW        = $clog2(BUZZ_PERIOD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  route_cmd_cntrl_if.slave     bus,
  input  logic                 OK2Move,
  output logic                 in_transit,
  output logic                 go,
  output logic                 buzz,
  output logic                 buzz_n,
  output logic [QCW-1:0]       q_cnt,
  output logic                 arrived,
  output logic                 cmd_err
);

  state_e          state;
  cmd_op_e         op;
  logic [ID_W-1:0] dest, id_rd, head;
  logic            push, pop, flush, q_full, q_empty, id_hit;
  logic            buzz_en;
  logic [BCW-1:0]  buzz_cnt;
  logic            unused_bits;

  assign op          = cmd_op_e'(bus.cmd[7:6]);
  assign dest        = bus.cmd[ID_W-1:0];
  assign id_rd       = bus.ID[ID_W-1:0];
  assign unused_bits = ^{bus.cmd, bus.ID};

  // A pending command always wins, so push and pop never coincide.
  assign bus.clr_cmd_rdy = bus.cmd_rdy;
  assign bus.clr_ID_vld  = bus.ID_vld && !bus.cmd_rdy;
  assign id_hit = bus.clr_ID_vld && (state == TRANSIT) && !q_empty && (id_rd == head);

  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    if (bus.cmd_rdy) begin
      case (op)
        CMD_STOP:   flush = 1'b1;
        CMD_GO:     begin flush = 1'b1; push = 1'b1; end
        CMD_APPEND: push = !q_full;
        default:    ;
      endcase
    end else begin
      pop = id_hit;
    end
  end

  dest_fifo #(.W(ID_W), .DEPTH(Q_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (dest),
    .head  (head),
    .cnt   (q_cnt),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_transit <= 1'b0;
      arrived    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      arrived <= 1'b0;
      cmd_err <= 1'b0;
      if (bus.cmd_rdy) begin
        case (op)
          CMD_STOP: begin
            state      <= IDLE;
            in_transit <= 1'b0;
          end
          CMD_GO: begin
            state      <= TRANSIT;
            in_transit <= 1'b1;
          end
          CMD_APPEND: begin
            if (q_full) begin
              cmd_err <= 1'b1;
            end else begin
              state      <= TRANSIT;
              in_transit <= 1'b1;
            end
          end
          default: cmd_err <= 1'b1;
        endcase
      end else if (id_hit && (q_cnt == QCW'(1))) begin
        state      <= IDLE;
        in_transit <= 1'b0;
        arrived    <= 1'b1;
      end
    end
  end

  assign go      = in_transit && OK2Move;
  assign buzz_en = in_transit && !OK2Move;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                buzz_cnt <= '0;
    else if (!buzz_en)                         buzz_cnt <= '0;
    else if (buzz_cnt == BCW'(BUZZ_PERIOD - 1)) buzz_cnt <= '0;
    else                                       buzz_cnt <= buzz_cnt + BCW'(1);
  end

  assign buzz   = buzz_en && (buzz_cnt < BCW'(BUZZ_HIGH));
  assign buzz_n = buzz_en && !buzz;

endmodule

// File: tb/tb_route_cmd_cntrl.sv
// Directed bench for route_cmd_cntrl: vector table plus hand-written corner sequences.
module tb_route_cmd_cntrl;
  import route_pkg::*;

  localparam int ID_W = 6, Q_DEPTH = 4, BUZZ_PERIOD = 10, BUZZ_HIGH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       OK2Move = 1'b1;
  logic       in_transit, go, buzz, buzz_n, arrived, cmd_err;
  logic [2:0] q_cnt;
  int         n_pass = 0, n_total = 0;

  route_cmd_cntrl_if bus_if ();

  route_cmd_cntrl #(
    .ID_W(ID_W), .Q_DEPTH(Q_DEPTH), .BUZZ_PERIOD(BUZZ_PERIOD), .BUZZ_HIGH(BUZZ_HIGH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if.slave),
    .OK2Move    (OK2Move),
    .in_transit (in_transit),
    .go         (go),
    .buzz       (buzz),
    .buzz_n     (buzz_n),
    .q_cnt      (q_cnt),
    .arrived    (arrived),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_id;
    logic [1:0] op;
    logic [7:0] data;
    logic       exp_it;
    logic [2:0] exp_q;
    logic       exp_arr;
    logic       exp_err;
  } vec_t;

  vec_t vecs [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    if (v.is_id) begin
      bus_if.ID     = v.data;
      bus_if.ID_vld = 1'b1;
    end else begin
      bus_if.cmd     = {v.op, v.data[5:0]};
      bus_if.cmd_rdy = 1'b1;
    end
    #1;
    chk($sformatf("ack[%0d]", idx), {bus_if.clr_cmd_rdy, bus_if.clr_ID_vld}, {~v.is_id, v.is_id});
    @(posedge clk);
    #1;
    bus_if.cmd_rdy = 1'b0;
    bus_if.ID_vld  = 1'b0;
    chk($sformatf("state[%0d]", idx), {in_transit, go, q_cnt, arrived, cmd_err},
        {v.exp_it, v.exp_it & OK2Move, v.exp_q, v.exp_arr, v.exp_err});
  endtask

  initial begin
    logic exp_b;
    bus_if.cmd = '0; bus_if.cmd_rdy = 1'b0; bus_if.ID = '0; bus_if.ID_vld = 1'b0;

    //        is_id op          data   it q     arr err
    vecs[0]  = '{1'b0, CMD_GO,     8'h05, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'b00,      8'h03, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b00,      8'h05, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 2'b00,      8'h05, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, CMD_GO,     8'h01, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, CMD_APPEND, 8'h02, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, CMD_APPEND, 8'h03, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, CMD_APPEND, 8'h04, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, CMD_APPEND, 8'h05, 1'b1, 3'd4, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 2'b00,      8'h02, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'b00,      8'h01, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'b00,      8'h02, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'b00,      8'h03, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 2'b00,      8'h04, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, CMD_APPEND, 8'h07, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, CMD_RSVD,   8'h07, 1'b1, 3'd1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, CMD_APPEND, 8'h08, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[17] = '{1'b0, CMD_GO,     8'h09, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 2'b00,      8'h07, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 2'b00,      8'hC9, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, CMD_APPEND, 8'h0A, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, CMD_APPEND, 8'h0B, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[22] = '{1'b0, CMD_APPEND, 8'h0C, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 2'b00,      8'h0B, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 2'b00,      8'h0A, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 2'b00,      8'h0B, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 2'b00,      8'h0C, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[27] = '{1'b0, CMD_STOP,   8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

    #12;
    chk("reset_outs", {in_transit, go, buzz, buzz_n, q_cnt, arrived, cmd_err}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) apply_vec(vecs[i], i);

    // Command and matching ID together: command first, ID later without a pop.
    apply_vec('{1'b0, CMD_GO, 8'h05, 1'b1, 3'd1, 1'b0, 1'b0}, 100);
    @(negedge clk);
    bus_if.cmd = {CMD_STOP, 6'h00}; bus_if.cmd_rdy = 1'b1;
    bus_if.ID  = 8'h05;             bus_if.ID_vld  = 1'b1;
    #1;
    chk("both_ack", {bus_if.clr_cmd_rdy, bus_if.clr_ID_vld}, 2'b10);
    @(posedge clk); #1;
    bus_if.cmd_rdy = 1'b0;
    chk("both_after_stop", {in_transit, q_cnt, arrived}, '0);
    @(negedge clk);
    chk("both_id_ack", {bus_if.clr_cmd_rdy, bus_if.clr_ID_vld}, 2'b01);
    @(posedge clk); #1;
    bus_if.ID_vld = 1'b0;
    chk("both_after_id", {in_transit, q_cnt, arrived, cmd_err}, '0);

    // Buzzer: two and a bit periods obstructed, then clear, then obstructed again.
    apply_vec('{1'b0, CMD_GO, 8'h03, 1'b1, 3'd1, 1'b0, 1'b0}, 101);
    apply_vec('{1'b0, CMD_APPEND, 8'h04, 1'b1, 3'd2, 1'b0, 1'b0}, 102);
    @(negedge clk);
    OK2Move = 1'b0;
    for (int k = 0; k < 24; k++) begin
      #1;
      exp_b = ((k % BUZZ_PERIOD) < BUZZ_HIGH);
      chk($sformatf("buzz[%0d]", k), {buzz, buzz_n, go}, {exp_b, ~exp_b, 1'b0});
      @(negedge clk);
    end
    OK2Move = 1'b1;
    #1;
    chk("buzz_clear", {buzz, buzz_n, go}, 3'b001);
    @(negedge clk);
    OK2Move = 1'b0;
    #1;
    chk("buzz_restart", {buzz, buzz_n, go}, 3'b100);

    // Asynchronous reset in the middle of a buzzing route.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {in_transit, go, buzz, buzz_n, q_cnt, arrived, cmd_err}, '0);
    @(negedge clk);
    rst_n   = 1'b1;
    OK2Move = 1'b1;
    @(posedge clk); #1;
    chk("post_rst", {in_transit, q_cnt}, '0);
    apply_vec('{1'b1, 2'b00, 8'h03, 1'b0, 3'd0, 1'b0, 1'b0}, 103);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
